rmii_rx_to_axis: RTL and testbench
==================================

Name: rmii_rx_to_axis

Overview:
- Receive half of the RMII MAC path, the counterpart of the RMII transmit block.
- Samples RMII RX dibits at 50 MHz (100BASE-TX only), strips preamble and SFD, and assembles bytes LSB-dibit-first.
- Emits each frame as an 8-bit AXIS packet with tlast on the final byte and tuser marking errored or truncated frames.
- FCS is passed through unchecked, for downstream CRC/MAC logic.

Parameters:
- MIN_PREAMBLE, 8: minimum count of consecutive 2'b01 dibits required before the SFD dibit 2'b11; fewer means the frame is ignored.

Ports:
- clk  input  1  50 MHz RMII reference clock; all logic on rising edge.
- sreset  input  1  synchronous active-high reset.
- rxd  input  2  RMII receive dibit.
- crs_dv  input  1  RMII carrier-sense/data-valid.
- rx_er  input  1  RMII receive error.
- rx_axis_tready  input  1  downstream ready.
- rx_axis_tvalid  output  1  byte valid.
- rx_axis_tlast  output  1  last byte of frame.
- rx_axis_tuser  output  1  frame error; meaningful only with tlast.
- rx_axis_tdata  output  8  received byte.
- overflow  output  1  one-cycle pulse when a byte is lost to backpressure.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on sreset.
- Reset: tvalid=0, tlast=0, tuser=0, tdata=0, overflow=0, state=IDLE, pending empty, error flag clear, dibit counter=0.
- IDLE:
  - crs_dv=1 with rxd=01 → PREAMBLE, preamble count=1.
  - Any other input → stay in IDLE.
- PREAMBLE:
  - rxd=01 → count++, saturating at MIN_PREAMBLE.
  - rxd=11 with count>=MIN_PREAMBLE → DATA, dibit counter=0.
  - rxd=11 with count<MIN_PREAMBLE, any other rxd value, or crs_dv=0 → DISCARD.
- DATA: byte assembly
  - Dibit position p (0..3) is written to byte bits [2p+1:2p].
  - At p=3 the byte is complete.
  - If pending is full, the old pending byte moves to the output register (tlast=0); the new byte becomes pending on the next cycle.
  - Latency: a byte appears on AXIS one cycle after the final dibit of the following byte, or one cycle after end-of-frame for the last byte.
- DATA: end-of-frame
  - End is declared when crs_dv=0 at both p=0 and p=2 of the same byte window.
  - crs_dv=0 at p=0 with crs_dv=1 at p=2 is the carrier-loss toggle: the dibits are data and reception continues.
  - On end, the partial window is discarded.
  - If pending is full, it goes to the output register with tlast=1 and tuser equal to the error flag; otherwise nothing is emitted.
  - Then → IDLE and the error flag clears.
- rx_er=1 in any cycle of DATA sets the error flag.
- Output register:
  - Follows the AXIS rule: once tvalid=1, tdata/tlast/tuser are held until tready=1.
  - Cleared on the handshake cycle unless reloaded in that same cycle.
  - Simultaneous accept and load is allowed, giving back-to-back bytes.
- Overflow:
  - Occurs when a byte must move to the output register while tvalid=1 and tready=0.
  - Effects: the byte is lost, overflow pulses for 1 cycle, and the block → DROP.
- DROP:
  - Ignores data until end-of-frame (same rule as DATA).
  - At end-of-frame, loads a terminator with tdata=0, tlast=1, tuser=1 when the output register is free, holding off IDLE until the load happens.
  - The previously pending byte is discarded.
- DISCARD: waits for crs_dv=0 at two consecutive samples, then → IDLE. No output.
- Throughput: at most 1 byte per 4 cycles, so a sink that stalls no more than 3 cycles per byte never overflows.
- sreset mid-frame: immediate return to reset state, in-flight bytes dropped. No tlast is generated.

Test Plan:
- Good frame: 7×0x55 + 0xD5 preamble/SFD, then 0xA5 (dibits 01,01,10,10), 0x3C, 0xFF, then crs_dv=0 with tready=1 → exactly 3 beats A5/3C/FF, tlast only on FF, tuser=0, overflow never pulses.
- Carrier-loss toggle: same frame with crs_dv pattern 0,0,1,1 over the final two bytes, then fully low → all bytes delivered intact and end detected once.
- rx_er: pulse for 1 cycle during the second byte of a 4-byte frame → 4 beats, data intact, tuser=1 on the tlast beat only.
- Backpressure: hold tready=0 from the first beat through 3 more bytes → overflow pulses once, first beat held stable, then terminator 0x00 with tlast=1 and tuser=1; the next frame is received cleanly.
- Short preamble: 3 dibits of 01 then 11 with MIN_PREAMBLE=8 → no AXIS output; the following valid frame is received.
- Reset: assert sreset mid-payload → all outputs 0 the next cycle, no tlast emitted; a subsequent frame is received normally.

Source files
------------

// File: rtl/rmii_rx_to_axis.sv
// rmii_rx_to_axis: RMII receive path that strips the preamble and SFD and emits frames as byte-wide AXIS packets.
`timescale 1ns/1ps
module rmii_rx_to_axis #(
  parameter int MIN_PREAMBLE = 8
) (
  input  logic       clk,
  input  logic       sreset,
  input  logic [1:0] rxd,
  input  logic       crs_dv,
  input  logic       rx_er,
  input  logic       rx_axis_tready,
  output logic       rx_axis_tvalid,
  output logic       rx_axis_tlast,
  output logic       rx_axis_tuser,
  output logic [7:0] rx_axis_tdata,
  output logic       overflow
);
  localparam int PW = $clog2(MIN_PREAMBLE + 1);
  localparam logic [PW-1:0] PMAX = PW'(MIN_PREAMBLE);
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DROP, DROP_EOF, DISCARD} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0] p_q, p_d;
  logic [5:0] shift_q, shift_d;
  logic [7:0] pend_q, pend_d, tdata_q, tdata_d, ld_data;
  logic cd0_q, cd0_d, pend_v_q, pend_v_d, err_q, err_d, disc_q, disc_d;
  logic tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d, ovf_q, ovf_d;
  logic load, ld_last, ld_user, free, eof;
  logic [7:0] byte_w;
  assign free   = !tvalid_q || rx_axis_tready;
  // a frame ends only when carrier is low at both p=0 and p=2 of one byte window
  assign eof    = p_q == 2'd2 && !crs_dv && cd0_q;
  assign byte_w = {rxd, shift_q};
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    p_d      = p_q;
    shift_d  = shift_q;
    cd0_d    = cd0_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    err_d    = err_q;
    disc_d   = disc_q;
    ovf_d    = 1'b0;
    load     = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    ld_user  = 1'b0;
    if (state_q == DATA || state_q == DROP) begin
      p_d     = p_q + 2'd1;
      shift_d = {rxd, shift_q[5:2]};
      cd0_d   = (p_q == 2'd0) ? !crs_dv : cd0_q;
    end
    case (state_q)
      IDLE: if (crs_dv && rxd == 2'b01) begin
        state_d = PREAMBLE;
        pre_d   = PW'(1);
      end
      PREAMBLE: begin
        if (crs_dv && rxd == 2'b01) pre_d = (pre_q == PMAX) ? pre_q : pre_q + 1'b1;
        else if (crs_dv && rxd == 2'b11 && pre_q == PMAX) begin
          state_d = DATA;
          p_d     = 2'd0;
          err_d   = 1'b0;
        end else begin
          state_d = DISCARD;
          disc_d  = 1'b0;
        end
      end
      DATA: begin
        err_d = err_q | rx_er;
        if (eof) begin
          state_d  = IDLE;
          p_d      = 2'd0;
          pend_v_d = 1'b0;
          err_d    = 1'b0;
          if (pend_v_q && free) begin
            load    = 1'b1;
            ld_data = pend_q;
            ld_last = 1'b1;
            ld_user = err_q | rx_er;
          end else if (pend_v_q) begin
            ovf_d   = 1'b1;
            state_d = DROP_EOF;
          end
        end else if (p_q == 2'd3) begin
          pend_d   = byte_w;
          pend_v_d = 1'b1;
          if (pend_v_q && free) begin
            load    = 1'b1;
            ld_data = pend_q;
          end else if (pend_v_q) begin
            ovf_d    = 1'b1;
            pend_v_d = 1'b0;
            state_d  = DROP;
          end
        end
      end
      DROP: state_d = eof ? DROP_EOF : DROP;
      DROP_EOF: if (free) begin
        load    = 1'b1;
        ld_last = 1'b1;
        ld_user = 1'b1;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      DISCARD: begin
        disc_d  = !crs_dv;
        state_d = (!crs_dv && disc_q) ? IDLE : DISCARD;
      end
      default: state_d = IDLE;
    endcase
    tvalid_d = load | (tvalid_q & !rx_axis_tready);
    tdata_d  = load ? ld_data : rx_axis_tready ? 8'h00 : tdata_q;
    tlast_d  = load ? ld_last : rx_axis_tready ? 1'b0 : tlast_q;
    tuser_d  = load ? ld_user : rx_axis_tready ? 1'b0 : tuser_q;
  end
  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      p_q      <= '0;
      shift_q  <= '0;
      cd0_q    <= 1'b0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      err_q    <= 1'b0;
      disc_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      p_q      <= p_d;
      shift_q  <= shift_d;
      cd0_q    <= cd0_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      err_q    <= err_d;
      disc_q   <= disc_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      ovf_q    <= ovf_d;
    end
  end
  assign rx_axis_tvalid = tvalid_q;
  assign rx_axis_tdata  = tdata_q;
  assign rx_axis_tlast  = tlast_q;
  assign rx_axis_tuser  = tuser_q;
  assign overflow       = ovf_q;
endmodule

// File: tb/tb_rmii_rx_to_axis.sv
// tb_rmii_rx_to_axis: randomized frames checked against a frame-level scoreboard of expected AXIS beats.
`timescale 1ns/1ps
module tb_rmii_rx_to_axis;
  logic clk = 1'b0;
  logic sreset = 1'b1;
  logic [1:0] rxd = 2'b00;
  logic crs_dv = 1'b0;
  logic rx_er = 1'b0;
  logic tready = 1'b1;
  logic tvalid, tlast, tuser, ovf;
  logic [7:0] tdata;
  typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
  beat_t exp_q[$];
  beat_t e_b;
  int n_vec = 0, n_err = 0, ovf_cnt = 0, exp_ovf = 0, mode = 2, zc = 0, plen = 0;
  logic [7:0] pl [16];
  logic [7:0] prev_d = '0;
  logic prev_stall = 1'b0;

  rmii_rx_to_axis #(.MIN_PREAMBLE(8)) dut (
    .clk(clk), .sreset(sreset), .rxd(rxd), .crs_dv(crs_dv), .rx_er(rx_er),
    .rx_axis_tready(tready), .rx_axis_tvalid(tvalid), .rx_axis_tlast(tlast),
    .rx_axis_tuser(tuser), .rx_axis_tdata(tdata), .overflow(ovf)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic dib(input logic [1:0] d, input logic c, input logic e);
    rxd = d;
    crs_dv = c;
    rx_er = e;
    @(posedge clk);
    #1;
  endtask

  // npre counts the 01 dibits before the 11 SFD dibit; a frame is accepted only when npre >= 8
  task automatic send_frame(input int npre, input int er_idx, input bit tog, input bit model);
    logic [7:0] cur;
    if (model && npre >= 8)
      for (int i = 0; i < plen; i++)
        exp_q.push_back('{d: pl[i], l: (i == plen - 1), u: (i == plen - 1) && er_idx >= 0});
    dib(2'b00, 1'b1, 1'b0);
    dib(2'b00, 1'b1, 1'b0);
    for (int i = 0; i < npre; i++) dib(2'b01, 1'b1, 1'b0);
    dib(2'b11, 1'b1, 1'b0);
    for (int i = 0; i < plen; i++) begin
      cur = pl[i];
      for (int k = 0; k < 4; k++)
        dib(cur[2*k +: 2], (tog && i >= plen - 2) ? (k >= 2) : 1'b1, er_idx == i && k == 1);
    end
    repeat (8) dib(2'b00, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(tag, exp_q.size(), 0);
    chk({tag, "_ovf"}, ovf_cnt, exp_ovf);
  endtask

  task automatic rand_payload(input int n);
    plen = n;
    for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mode == 1) tready = 1'b0;
      else if (mode == 2) tready = 1'b1;
      else tready = (zc >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      zc = tready ? 0 : zc + 1;
    end
  end

  always @(negedge clk) begin
    if (ovf) ovf_cnt++;
    if (prev_stall && !sreset) begin
      chk("hold_valid", tvalid, 1);
      chk("hold_data", tdata, prev_d);
    end
    prev_stall = tvalid && !tready && !sreset;
    prev_d = tdata;
    if (tvalid && tready) begin
      chk("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e_b = exp_q.pop_front();
        chk("tdata", tdata, e_b.d);
        chk("tlast", tlast, e_b.l);
        chk("tuser", tuser, e_b.u);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int npre, er;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_ovf", ovf, 0);
    sreset = 1'b0;
    repeat (4) dib(2'b00, 1'b0, 1'b0);
    plen = 3; pl[0] = 8'hA5; pl[1] = 8'h3C; pl[2] = 8'hFF;
    send_frame(31, -1, 0, 1);
    drain("good");
    send_frame(31, -1, 1, 1);
    drain("toggle");
    rand_payload(4);
    send_frame(31, 1, 0, 1);
    drain("rx_er");
    for (int t = 0; t < 12; t++) begin
      mode = 0;
      rand_payload($urandom_range(1, 12));
      npre = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 31);
      er = ($urandom_range(0, 3) == 0) ? $urandom_range(0, plen - 1) : -1;
      send_frame(npre, er, npre >= 8 && $urandom_range(0, 1) == 1, 1);
      drain("rand");
    end
    mode = 1;
    rand_payload(4);
    exp_q.push_back('{d: pl[0], l: 1'b0, u: 1'b0});
    exp_q.push_back('{d: 8'h00, l: 1'b1, u: 1'b1});
    exp_ovf++;
    send_frame(31, -1, 0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("bp_valid", tvalid, 1);
    chk("bp_first", tdata, pl[0]);
    chk("bp_ovf_once", ovf_cnt, exp_ovf);
    mode = 2;
    drain("bp_term");
    mode = 0;
    rand_payload(6);
    send_frame(31, -1, 0, 1);
    drain("after_bp");
    rand_payload(3);
    send_frame(3, -1, 0, 1);
    rand_payload(5);
    send_frame(31, -1, 0, 1);
    drain("short_pre");
    mode = 2;
    repeat (2) @(posedge clk);
    #1;
    rand_payload(4);
    exp_q.push_back('{d: pl[0], l: 1'b0, u: 1'b0});
    for (int i = 0; i < 31; i++) dib(2'b01, 1'b1, 1'b0);
    dib(2'b11, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) dib(pl[i/4][2*(i%4) +: 2], 1'b1, 1'b0);
    sreset = 1'b1;
    crs_dv = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_tvalid", tvalid, 0);
    chk("mid_tlast", tlast, 0);
    chk("mid_tuser", tuser, 0);
    chk("mid_tdata", tdata, 0);
    chk("mid_ovf", ovf, 0);
    sreset = 1'b0;
    repeat (8) dib(2'b00, 1'b0, 1'b0);
    drain("mid_rst");
    mode = 0;
    rand_payload(7);
    send_frame(31, -1, 0, 1);
    drain("after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
